// File: rtl/usb_reg_cmd_parser_if.sv
// Bus bundle between the USB command parser, the USB FIFO bridge and the
// 8-bit register memory. The parser side uses the master modport. The
// bridge/memory side uses the slave modport.
interface usb_reg_cmd_parser_if #(
   parameter int ADDR_W = 4
);
   // receive byte stream from the bridge
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;

   // read-back byte stream to the bridge
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;

   // register memory access
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_we;
   logic              reg_oe;
   logic [7:0]        reg_rdata;

   // status
   logic              busy;
   logic              err_timeout;
   logic              err_cmd;

   modport master (
      input  rx_data, rx_valid, tx_ready, reg_rdata,
      output rx_ready, tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_oe,
             busy, err_timeout, err_cmd
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, reg_rdata,
      input  rx_ready, tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_oe,
             busy, err_timeout, err_cmd
   );
endinterface

// File: rtl/usb_reg_cmd_parser.sv
// USB command parser: decodes a host byte stream into single-register
// writes and reads on the register memory. Read data goes back to the host
// as one byte. A write command whose data byte never arrives is abandoned
// after TIMEOUT_CYCLES, so the link cannot hang.
//
// Command byte: bit7 = 1 for write, 0 for read; bits[ADDR_W-1:0] = address;
// bits[6:ADDR_W] are reserved and must be zero.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a command byte (rx_ready=1)
// S_GET_DATA  | write command accepted, waiting for its data byte, timing out
// S_WRITE     | one-cycle reg_we/reg_oe strobe to the memory
// S_READ_WAIT | address is stable, sampling reg_rdata into tx_data
// S_SEND      | presenting tx_data until the bridge accepts it
module usb_reg_cmd_parser #(
   parameter int ADDR_W         = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  useClk,
   input  logic                  rst_n,
   usb_reg_cmd_parser_if.master  bus
);

   localparam int          CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  ADDR_MASK = 8'((1 << ADDR_W) - 1);
   // Every bit below the write flag that is not an address bit is reserved.
   localparam logic [7:0]  RSVD_MASK = 8'h7F & ~ADDR_MASK;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GET_DATA  = 3'd1,
      S_WRITE     = 3'd2,
      S_READ_WAIT = 3'd3,
      S_SEND      = 3'd4
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_wdata;
   logic [7:0]        r_tx_data;
   logic              r_tx_valid;
   logic              r_we;
   logic              r_err_timeout;
   logic              r_err_cmd;

   logic              w_rx_ready;
   logic              w_rx_fire;
   logic              w_tx_fire;
   logic              w_cmd_bad;
   logic              w_cmd_write;
   logic              w_timeout;

   // rx_ready is gated by rst_n so that it reads 0 while reset is held.
   // It rises as soon as reset is released with the FSM in IDLE.
   assign w_rx_ready  = rst_n && ((r_state == S_IDLE) || (r_state == S_GET_DATA));
   assign w_rx_fire   = bus.rx_valid && w_rx_ready;
   assign w_tx_fire   = r_tx_valid && bus.tx_ready;
   assign w_cmd_bad   = |(bus.rx_data & RSVD_MASK);
   assign w_cmd_write = bus.rx_data[7];
   assign w_timeout   = (r_cnt == CNT_LAST);

   // Command sequencing FSM with registered strobes, data and error pulses
   always_ff @(posedge useClk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_tx_data     <= '0;
         r_tx_valid    <= 1'b0;
         r_we          <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_cmd     <= 1'b0;
      end else begin
         r_we          <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_cmd     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rx_fire) begin
                  if (w_cmd_bad) begin
                     r_err_cmd <= 1'b1;
                  end else begin
                     r_addr <= bus.rx_data[ADDR_W-1:0];
                     if (w_cmd_write) begin
                        r_cnt   <= '0;
                        r_state <= S_GET_DATA;
                     end else begin
                        r_state <= S_READ_WAIT;
                     end
                  end
               end
            end
            S_GET_DATA: begin
               // A data byte that arrives on the timeout edge still counts.
               if (w_rx_fire) begin
                  r_wdata <= bus.rx_data;
                  r_we    <= 1'b1;
                  r_state <= S_WRITE;
               end else if (w_timeout) begin
                  r_err_timeout <= 1'b1;
                  r_state       <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               r_state <= S_IDLE;
            end
            S_READ_WAIT: begin
               r_tx_data  <= bus.reg_rdata;
               r_tx_valid <= 1'b1;
               r_state    <= S_SEND;
            end
            S_SEND: begin
               if (w_tx_fire) begin
                  r_tx_valid <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_tx_valid <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rx_ready    = w_rx_ready;
   assign bus.tx_data     = r_tx_data;
   assign bus.tx_valid    = r_tx_valid;
   assign bus.reg_addr    = r_addr;
   assign bus.reg_wdata   = r_wdata;
   // The memory's data-check input and its oe are strobed together. Both come
   // from the same flop, so neither one can be high outside S_WRITE.
   assign bus.reg_we      = r_we;
   assign bus.reg_oe      = r_we;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.err_timeout = r_err_timeout;
   assign bus.err_cmd     = r_err_cmd;

endmodule

// File: doc/usb_reg_cmd_parser.md
Name: usb_reg_cmd_parser

Overview:
- Upstream command stage for the 8-bit register memory.
- Consumes a byte stream from the USB FIFO bridge and decodes it into single-register write and read transactions on the memory's address/data/strobe interface.
- Returns read data to the host as a byte on the transmit stream.
- One-command-at-a-time FSM with a data-byte timeout so a truncated write cannot hang the link.

Parameters:
- ADDR_W, 4, register address width; legal range 1..4 (command byte format fixes the maximum at 4).
- TIMEOUT_CYCLES, 1024, useClk cycles allowed between a write command byte and its data byte; minimum 2.

Ports:
- useClk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  byte from USB bridge.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  parser accepts rx_data this cycle.
- tx_data  output  8  read-back byte to USB bridge.
- tx_valid  output  1  tx_data valid; held until accepted.
- tx_ready  input  1  bridge accepts tx_data.
- reg_addr  output  ADDR_W  address to register memory.
- reg_wdata  output  8  write data to register memory.
- reg_we  output  1  write strobe; drives the memory's data-check input.
- reg_oe  output  1  write enable qualifier; drives the memory's oe.
- reg_rdata  input  8  combinational read data from register memory at reg_addr.
- busy  output  1  high in any state other than IDLE.
- err_timeout  output  1  one-cycle pulse when a write data byte times out.
- err_cmd  output  1  one-cycle pulse when a command byte has nonzero reserved bits.

Behaviour:
- Clock and reset: one clock (useClk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - State goes to IDLE.
  - rx_ready=0, tx_valid=0, tx_data=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_oe=0.
  - busy=0, err_timeout=0, err_cmd=0, timeout counter=0.
  - rx_ready rises combinationally once out of reset in IDLE.
  - Reset mid-transaction abandons it; no partial write is issued.
- Command byte format:
  - bit7=1: write; bit7=0: read.
  - bits[ADDR_W-1:0]: address.
  - bits[6:ADDR_W] are reserved and must be 0.
- Transfer rule: a byte transfers on a clock edge where rx_valid && rx_ready. tx transfers on tx_valid && tx_ready.
- IDLE: rx_ready=1. On command transfer:
  - Reserved bits nonzero: pulse err_cmd next cycle, stay IDLE, byte dropped.
  - Otherwise latch reg_addr.
  - Write command: go to GET_DATA; clear timeout counter.
  - Read command: go to READ_WAIT.
- GET_DATA: rx_ready=1; counter increments each cycle with no transfer.
  - On transfer: latch reg_wdata, go to WRITE.
  - Counter reaching TIMEOUT_CYCLES-1 with no transfer: pulse err_timeout, return to IDLE, no write issued.
  - A transfer on the same edge as the timeout wins; no error.
- WRITE: reg_we=1 and reg_oe=1 for exactly one cycle, then IDLE. rx_ready=0.
- READ_WAIT: one cycle; reg_addr stable; capture reg_rdata into tx_data at end of cycle; go to SEND. rx_ready=0.
- SEND: tx_valid=1, tx_data held stable until tx_ready; on transfer go to IDLE. rx_ready=0. No timeout; backpressure is unbounded.
- Latency:
  - Write: data byte accepted at edge E; reg_we high during cycle after E; memory updated at edge E+1.
  - Read: command accepted at edge E; tx_valid high from cycle after E+1. Minimum read turnaround is 3 cycles back to IDLE.
- Coherence: a read immediately after a write to the same address returns the new data.
- reg_we and reg_oe are never high outside WRITE.
- reg_addr and reg_wdata hold their last values between transactions.

Test Plan:
- Reset: assert rst_n=0 mid-SEND -> tx_valid=0, busy=0, reg_we=0 immediately (async); after release rx_ready=1.
- Write then read: send 0x83 then 0x5A, then 0x03 -> one reg_we pulse with reg_addr=3, reg_wdata=0x5A; tx_data=0x5A presented with tx_valid; busy low after tx accept.
- Backpressure: read 0x07 with tx_ready held low 20 cycles -> tx_valid stays 1 with tx_data stable; rx_ready=0 throughout; completes one cycle after tx_ready=1.
- Timeout: TIMEOUT_CYCLES=8, send 0x85 and no data -> err_timeout pulses once 8 cycles later; no reg_we; next 0x05 read returns the previous contents of address 5.
- Bad command: send 0x30 (ADDR_W=4) -> err_cmd one-cycle pulse; no reg_we; no tx_valid; parser accepts 0x02 next cycle.
- Back-to-back: sixteen writes addr 0..15 data 0xF0+addr with rx_valid held high -> exactly sixteen reg_we pulses, each one cycle; readback of all sixteen returns matching data.
